// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - six-stage pipeline stall/flush controller with multi-cycle EX sequencer.
// Optional consecutive-stall watchdog built only when STALL_WATCHDOG_EN is defined.
module pipeline_stall_ctrl #(
  parameter int COUNT_WIDTH    = 6,
  parameter int WATCHDOG_LIMIT = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_stall_request,
  input  logic                   ex_multicycle_start,
  input  logic [COUNT_WIDTH-1:0] ex_multicycle_cycles,
  input  logic                   mem_stall_request,
  input  logic                   flush_request,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic                   ex_busy,
  output logic                   ex_done,
  output logic                   stall_timeout
);

  typedef enum logic [1:0] {IDLE, EX_BUSY, EX_DONE} state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   start_ok;
  logic                   ex_stall;

  always_comb begin
    start_ok = ex_multicycle_start && (state != EX_BUSY) &&
               !flush_request && !mem_stall_request;
    ex_stall = start_ok || (state == EX_BUSY);
  end

  // Priority merge; everything is forced quiet while reset is held.
  always_comb begin
    stall = 6'b000000;
    if (!reset)                 stall = 6'b000000;
    else if (flush_request)     stall = 6'b000000;
    else if (mem_stall_request) stall = 6'b011111;
    else if (ex_stall)          stall = 6'b001111;
    else if (id_stall_request)  stall = 6'b000111;
  end

  always_comb begin
    flush   = reset && flush_request;
    ex_busy = reset && (state == EX_BUSY);
    ex_done = reset && (state == EX_DONE) && !mem_stall_request && !flush_request;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else if (flush_request) begin
      state     <= IDLE;
      remaining <= '0;
    end else if (mem_stall_request) begin
      state     <= state;
      remaining <= remaining;
    end else if (start_ok) begin
      if (ex_multicycle_cycles <= ONE) begin
        state     <= EX_DONE;
        remaining <= '0;
      end else begin
        state     <= EX_BUSY;
        remaining <= ex_multicycle_cycles - ONE;
      end
    end else begin
      case (state)
        EX_BUSY: begin
          if (remaining == ONE) begin
            state     <= EX_DONE;
            remaining <= '0;
          end else begin
            remaining <= remaining - ONE;
          end
        end
        EX_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STALL_WATCHDOG_EN
  localparam int            WD_W   = $clog2(WATCHDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_LIMIT);

  logic [WD_W-1:0] wd_count;
  logic [WD_W-1:0] wd_next;
  logic            timeout_q;

  always_comb begin
    wd_next = wd_count;
    if (!stall[0] || flush_request) wd_next = '0;
    else if (wd_count != WD_MAX)    wd_next = wd_count + WD_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_count  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_count  <= wd_next;
      timeout_q <= timeout_q || (wd_next == WD_MAX);
    end
  end

  assign stall_timeout = timeout_q;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed vector bench for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_stall_request;
  logic       ex_multicycle_start;
  logic [5:0] ex_multicycle_cycles;
  logic       mem_stall_request;
  logic       flush_request;
  logic [5:0] stall;
  logic       flush;
  logic       ex_busy;
  logic       ex_done;
  logic       stall_timeout;

  int tests = 0;
  int fails = 0;

  pipeline_stall_ctrl #(.COUNT_WIDTH(6), .WATCHDOG_LIMIT(8)) dut (
    .clock               (clock),
    .reset               (reset),
    .id_stall_request    (id_stall_request),
    .ex_multicycle_start (ex_multicycle_start),
    .ex_multicycle_cycles(ex_multicycle_cycles),
    .mem_stall_request   (mem_stall_request),
    .flush_request       (flush_request),
    .stall               (stall),
    .flush               (flush),
    .ex_busy             (ex_busy),
    .ex_done             (ex_done),
    .stall_timeout       (stall_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       id;
    logic       st;
    logic [5:0] n;
    logic       mem;
    logic       fl;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input logic id, input logic st, input int n, input logic mem, input logic fl,
                     input logic [5:0] s, input logic f, input logic b, input logic d);
    vecs[nv].id  = id;
    vecs[nv].st  = st;
    vecs[nv].n   = 6'(n);
    vecs[nv].mem = mem;
    vecs[nv].fl  = fl;
    vecs[nv].exp = {s, f, b, d, 1'b0};
    nv++;
  endtask

  task automatic drive(input logic id, input logic st, input int n, input logic mem, input logic fl);
    id_stall_request     = id;
    ex_multicycle_start  = st;
    ex_multicycle_cycles = 6'(n);
    mem_stall_request    = mem;
    flush_request        = fl;
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  logic done_seen;
  logic wd_exp;

  initial begin
    // id st n mem fl | stall flush busy done
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(1,0,0,0,0, 6'b000111,0,0,0);
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(0,1,4,0,0, 6'b001111,0,0,0);  // N=4: T0
    add(0,0,0,0,0, 6'b001111,0,1,0);
    add(0,0,0,0,0, 6'b001111,0,1,0);
    add(0,0,0,0,0, 6'b001111,0,1,0);
    add(0,0,0,0,0, 6'b000000,0,0,1);  // T4 done
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(0,1,3,0,0, 6'b001111,0,0,0);  // N=3 with 2 mem-stall cycles
    add(0,0,0,1,0, 6'b011111,0,1,0);
    add(0,0,0,1,0, 6'b011111,0,1,0);
    add(0,0,0,0,0, 6'b001111,0,1,0);
    add(0,0,0,0,0, 6'b001111,0,1,0);
    add(0,0,0,0,0, 6'b000000,0,0,1);  // T5 done
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(0,1,5,0,0, 6'b001111,0,0,0);  // N=5 flushed at T2
    add(0,0,0,0,0, 6'b001111,0,1,0);
    add(0,0,0,0,1, 6'b000000,1,1,0);
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(0,1,1,0,0, 6'b001111,0,0,0);  // N=1
    add(0,0,0,0,0, 6'b000000,0,0,1);
    add(0,1,0,0,0, 6'b001111,0,0,0);  // N=0 behaves as 1
    add(0,1,2,0,0, 6'b001111,0,0,1);  // back-to-back start in EX_DONE
    add(1,1,3,0,0, 6'b001111,0,1,0);  // start in EX_BUSY ignored
    add(1,0,0,0,0, 6'b000111,0,0,1);
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(0,1,2,1,0, 6'b011111,0,0,0);  // start blocked by MEM
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(1,1,1,0,0, 6'b001111,0,0,0);  // EX wins over ID
    add(0,0,0,1,0, 6'b011111,0,0,0);  // done withheld by MEM
    add(0,0,0,0,1, 6'b000000,1,0,0);  // flush aborts pending done
    add(0,0,0,0,0, 6'b000000,0,0,0);
    add(0,1,2,0,1, 6'b000000,1,0,0);  // start blocked by flush
    add(0,0,0,0,0, 6'b000000,0,0,0);

    reset = 1'b0;
    drive(1, 1, 3, 1, 1);
    #12;
    chk("reset_stall",   {4'b0, stall},      10'd0);
    chk("reset_flush",   {9'b0, flush},      10'd0);
    chk("reset_done",    {9'b0, ex_done},    10'd0);
    chk("reset_busy",    {9'b0, ex_busy},    10'd0);
    chk("reset_timeout", {9'b0, stall_timeout}, 10'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("post_reset", {stall, flush, ex_busy, ex_done, stall_timeout}, 10'd0);

    for (int i = 0; i < nv; i++) begin
      @(posedge clock); #1;
      drive(vecs[i].id, vecs[i].st, int'(vecs[i].n), vecs[i].mem, vecs[i].fl);
      @(negedge clock);
      chk($sformatf("vec%0d", i), {stall, flush, ex_busy, ex_done, stall_timeout}, vecs[i].exp);
    end

`ifdef STALL_WATCHDOG_EN
    wd_exp = 1'b1;
`else
    wd_exp = 1'b0;
`endif
    // 8 consecutive MEM-stall cycles against a limit of 8
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      drive(0, 0, 0, 1, 0);
    end
    @(negedge clock);
    chk("wd_before_limit", {9'b0, stall_timeout}, 10'd0);
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("wd_at_limit", {9'b0, stall_timeout}, {9'b0, wd_exp});
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("wd_sticky", {9'b0, stall_timeout}, {9'b0, wd_exp});

    // reset asserted in the middle of a multi-cycle op
    @(posedge clock); #1;
    drive(0, 1, 6, 0, 0);
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("midop_busy_before", {stall, ex_busy, 3'b0}, {6'b001111, 1'b1, 3'b0});
    reset = 1'b0;
    #1;
    chk("midop_reset", {stall, flush, ex_busy, ex_done, stall_timeout}, 10'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midop_after", {stall, flush, ex_busy, ex_done, stall_timeout}, 10'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (ex_done) done_seen = 1'b1;
    end
    chk("midop_no_done", {9'b0, done_seen}, 10'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
